// File: rtl/cfs_neuron_scheduler.sv
// cfs_neuron_scheduler: CPU-programmed sequencer that walks a neuron index range through a LIF engine
module cfs_neuron_scheduler #(
    parameter int IDX_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             bus_re_i,
    input  logic             bus_we_i,
    input  logic [1:0]       bus_addr_i,
    input  logic [31:0]      bus_wdata_i,
    output logic [31:0]      bus_rdata_o,
    output logic             bus_ack_o,
    output logic             eng_req_o,
    output logic [IDX_W-1:0] eng_idx_o,
    input  logic             eng_ack_i,
    input  logic             eng_spike_i,
    output logic             irq_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, FINISH} state_t;

    state_t           state;
    logic             irq_en;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] count;
    logic [IDX_W-1:0] k;
    logic [TW-1:0]    wcnt;
    logic             done;
    logic             timeout;
    logic [15:0]      spikes;
    logic             busy;
    logic             wr_ctrl;
    logic             wr_status;
    logic             start;
    logic             abort;
    logic             last;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign busy         = state != IDLE;
    assign wr_ctrl      = bus_we_i && bus_addr_i == 2'd0;
    assign wr_status    = bus_we_i && bus_addr_i == 2'd3;
    assign abort        = wr_ctrl && bus_wdata_i[2];
    // ABORT in the same write as START suppresses the run
    assign start        = wr_ctrl && bus_wdata_i[0] && !bus_wdata_i[2];
    assign last         = k == count - IDX_W'(1);
    assign irq_o        = irq_en && done;
    assign unused_wdata = ^bus_wdata_i;

    assign rd_mux = bus_addr_i == 2'd0 ? {30'd0, irq_en, 1'b0} :
                    bus_addr_i == 2'd1 ? 32'(base) :
                    bus_addr_i == 2'd2 ? 32'(count) :
                    {spikes, 13'd0, timeout, done, busy};

    // Register file and one-cycle bus acknowledge; read data is zero unless answering a read
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bus_ack_o   <= 1'b0;
            bus_rdata_o <= '0;
            irq_en      <= 1'b0;
            base        <= '0;
            count       <= '0;
        end else begin
            bus_ack_o   <= bus_re_i || bus_we_i;
            bus_rdata_o <= bus_re_i ? rd_mux : '0;
            if (wr_ctrl)
                irq_en <= bus_wdata_i[1];
            if (bus_we_i && !busy && bus_addr_i == 2'd1)
                base <= bus_wdata_i[IDX_W-1:0];
            if (bus_we_i && !busy && bus_addr_i == 2'd2)
                count <= bus_wdata_i[IDX_W-1:0];
        end
    end

    // Run sequencer with registered engine outputs; flag sets are written last so they beat W1C
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            k         <= '0;
            wcnt      <= '0;
            spikes    <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            eng_req_o <= 1'b0;
            eng_idx_o <= '0;
        end else begin
            if (wr_status && bus_wdata_i[1])
                done <= 1'b0;
            if (wr_status && bus_wdata_i[2])
                timeout <= 1'b0;
            if (abort && busy) begin
                state     <= IDLE;
                eng_req_o <= 1'b0;
                eng_idx_o <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        k         <= '0;
                        wcnt      <= '0;
                        spikes    <= '0;
                        done      <= 1'b0;
                        timeout   <= 1'b0;
                        state     <= count != '0 ? ISSUE : FINISH;
                        eng_req_o <= count != '0;
                        eng_idx_o <= count != '0 ? base : '0;
                    end
                    ISSUE: if (eng_ack_i) begin
                        spikes    <= spikes + 16'(eng_spike_i && spikes != 16'hFFFF);
                        k         <= last ? k : k + IDX_W'(1);
                        state     <= last ? FINISH : GAP;
                        eng_req_o <= 1'b0;
                        eng_idx_o <= '0;
                    end else if (wcnt == WAIT_LAST) begin
                        timeout   <= 1'b1;
                        state     <= FINISH;
                        eng_req_o <= 1'b0;
                        eng_idx_o <= '0;
                    end else begin
                        wcnt <= wcnt + TW'(1);
                    end
                    GAP: begin
                        wcnt      <= '0;
                        state     <= ISSUE;
                        eng_req_o <= 1'b1;
                        eng_idx_o <= base + k;
                    end
                    FINISH: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cfs_neuron_scheduler.sv
// tb_cfs_neuron_scheduler: scoreboard bench with a behavioural engine and index/spike model
module tb_cfs_neuron_scheduler;
    typedef struct {
        logic [15:0] idx;
        bit          first;
        int          hi;
    } req_t;

    logic        clk;
    logic        rstn;
    logic        bus_re;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        eng_req;
    logic [15:0] eng_idx;
    logic        eng_ack;
    logic        eng_spike;
    logic        irq;

    req_t        idx_q[$];
    logic [31:0] rd_q[$];
    int          lat_q[$];
    bit          spk_q[$];
    int          vectors;
    int          miscompares;
    int          req_seen;
    int          hi_cnt;
    int          low_cnt;
    int          cur_hi;
    int          held;
    int          cur_lat;
    bit          req_prev;
    bit          strobe_d;
    bit          stray;
    req_t        cur;

    cfs_neuron_scheduler #(.IDX_W(16), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk),
        .rstn_i(rstn),
        .bus_re_i(bus_re),
        .bus_we_i(bus_we),
        .bus_addr_i(bus_addr),
        .bus_wdata_i(bus_wdata),
        .bus_rdata_o(bus_rdata),
        .bus_ack_o(bus_ack),
        .eng_req_o(eng_req),
        .eng_idx_o(eng_idx),
        .eng_ack_i(eng_ack),
        .eng_spike_i(eng_spike),
        .irq_o(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1; strobe is sampled at the next posedge
    task automatic bus_access(input bit wr, input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = wr;
        bus_re    = !wr;
        rd_q.push_back(wr ? 32'd0 : exp);
        @(posedge clk);
        #1;
        bus_we = 1'b0;
        bus_re = 1'b0;
    endtask

    task automatic wait_irq(input int lim);
        int c = 0;
        while (!irq && c < lim) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("irq_wait", {31'd0, irq}, 32'd1);
    endtask

    task automatic wait_reqs(input int n, input int lim);
        int target = req_seen + n;
        int c = 0;
        while (req_seen < target && c < lim) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("req_wait", {31'd0, req_seen >= target}, 32'd1);
    endtask

    // Full run: model says index i is (b+i) mod 2^16 and SPIKES is the sum of spike bits
    task automatic run(input logic [15:0] b, input int n, input int lat_fix, input logic [31:0] spk_pat, input bit stray_en);
        int          sum = 0;
        int          lat;
        logic [31:0] w;
        w       = $urandom;
        w[15:0] = b;
        bus_access(1'b1, 2'd1, w, 32'd0);
        bus_access(1'b1, 2'd2, 32'(n), 32'd0);
        for (int i = 0; i < n; i++) begin
            lat = lat_fix != 0 ? lat_fix : int'($urandom_range(1, 4));
            idx_q.push_back('{idx: 16'(int'(b) + i), first: i == 0, hi: lat});
            lat_q.push_back(lat);
            spk_q.push_back(spk_pat[i]);
            sum += int'(spk_pat[i]);
        end
        stray = stray_en;
        bus_access(1'b1, 2'd0, 32'h3, 32'd0);
        wait_irq(400);
        stray = 1'b0;
        bus_access(1'b0, 2'd3, 32'd0, {16'(sum), 16'h0002});
        bus_access(1'b1, 2'd3, 32'h6, 32'd0);
        check("irq_after_w1c", {31'd0, irq}, 32'd0);
        bus_access(1'b0, 2'd3, 32'd0, {16'(sum), 16'h0000});
    endtask

    always @(posedge clk) strobe_d <= rstn && (bus_re || bus_we);

    // Monitor: pops expected read data and engine indices as the DUT presents them
    always @(negedge clk) begin
        if (rstn) begin
            if (bus_ack || strobe_d)
                check("bus_ack", {31'd0, bus_ack}, {31'd0, strobe_d});
            if (bus_ack) begin
                if (rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL bus_rdata: ack with no access outstanding, rdata 0x%08h", bus_rdata);
                end else begin
                    check("bus_rdata", bus_rdata, rd_q.pop_front());
                end
            end
            if (eng_req && !req_prev) begin
                req_seen++;
                if (idx_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL eng_req: unexpected request idx 0x%04h, none expected", eng_idx);
                    cur_hi = 0;
                end else begin
                    cur = idx_q.pop_front();
                    check("eng_idx", {16'd0, eng_idx}, {16'd0, cur.idx});
                    if (!cur.first)
                        check("gap_cycles", 32'(low_cnt), 32'd1);
                    cur_hi = cur.hi;
                end
                hi_cnt = 0;
            end
            if (eng_req) begin
                hi_cnt++;
                low_cnt = 0;
            end else begin
                low_cnt++;
            end
            if (!eng_req && req_prev) begin
                check("idx_idle_zero", {16'd0, eng_idx}, 32'd0);
                if (cur_hi != 0)
                    check("req_hold_cycles", 32'(hi_cnt), 32'(cur_hi));
            end
            req_prev = eng_req;
        end else begin
            req_prev = 1'b0;
            low_cnt  = 0;
            hi_cnt   = 0;
            cur_hi   = 0;
        end
    end

    // Engine model: acks after a per-request latency, 0 means never; optional stray acks while idle
    initial begin
        eng_ack   = 1'b0;
        eng_spike = 1'b0;
        held      = 0;
        cur_lat   = 0;
        forever begin
            @(posedge clk);
            #1;
            eng_ack   = 1'b0;
            eng_spike = 1'b0;
            if (!eng_req) begin
                held = 0;
                if (stray && $urandom_range(0, 3) == 0) begin
                    eng_ack   = 1'b1;
                    eng_spike = 1'b1;
                end
            end else begin
                held++;
                if (held == 1)
                    cur_lat = lat_q.size() != 0 ? lat_q.pop_front() : 0;
                if (held == cur_lat) begin
                    eng_ack   = 1'b1;
                    eng_spike = spk_q.size() != 0 ? spk_q.pop_front() : 1'b0;
                end
            end
        end
    end

    initial begin
        logic [15:0] b;
        vectors     = 0;
        miscompares = 0;
        req_seen    = 0;
        stray       = 1'b0;
        rstn        = 1'b0;
        bus_re      = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = 2'd0;
        bus_wdata   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_eng_req", {31'd0, eng_req}, 32'd0);
        check("rst_eng_idx", {16'd0, eng_idx}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_bus_ack", {31'd0, bus_ack}, 32'd0);
        check("rst_bus_rdata", bus_rdata, 32'd0);
        rstn = 1'b1;
        for (int a = 0; a < 4; a++)
            bus_access(1'b0, 2'(a), 32'd0, 32'd0);
        bus_access(1'b1, 2'd0, 32'h2, 32'd0);
        bus_access(1'b0, 2'd0, 32'd0, 32'h2);
        bus_access(1'b1, 2'd1, 32'hABCD1234, 32'd0);
        bus_access(1'b0, 2'd1, 32'd0, 32'h0000_1234);
        bus_access(1'b1, 2'd2, 32'hFFFF0007, 32'd0);
        bus_access(1'b0, 2'd2, 32'd0, 32'h0000_0007);

        run(16'h0010, 3, 2, 32'b101, 1'b0);
        run(16'hFFFE, 4, 0, $urandom, 1'b1);
        for (int r = 0; r < 6; r++) begin
            b = $urandom_range(0, 3) == 0 ? 16'(16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
            run(b, int'($urandom_range(1, 6)), 0, $urandom, 1'b1);
        end

        bus_access(1'b1, 2'd2, 32'd0, 32'd0);
        bus_access(1'b1, 2'd0, 32'h3, 32'd0);
        check("cnt0_irq_early", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        check("cnt0_irq", {31'd0, irq}, 32'd1);
        bus_access(1'b0, 2'd3, 32'd0, 32'h2);
        bus_access(1'b1, 2'd3, 32'h2, 32'd0);
        check("cnt0_irq_clr", {31'd0, irq}, 32'd0);

        bus_access(1'b1, 2'd1, 32'h0100, 32'd0);
        bus_access(1'b1, 2'd2, 32'd3, 32'd0);
        idx_q.push_back('{idx: 16'h0100, first: 1'b1, hi: 8});
        lat_q.push_back(0);
        bus_access(1'b1, 2'd0, 32'h3, 32'd0);
        bus_access(1'b0, 2'd3, 32'd0, 32'h1);
        bus_access(1'b1, 2'd1, 32'h5555, 32'd0);
        wait_irq(50);
        bus_access(1'b0, 2'd3, 32'd0, 32'h6);
        bus_access(1'b0, 2'd1, 32'd0, 32'h0100);
        check("timeout_req_low", {31'd0, eng_req}, 32'd0);
        bus_access(1'b1, 2'd3, 32'h6, 32'd0);
        bus_access(1'b0, 2'd3, 32'd0, 32'h0);

        bus_access(1'b1, 2'd1, 32'h0200, 32'd0);
        bus_access(1'b1, 2'd2, 32'd5, 32'd0);
        idx_q.push_back('{idx: 16'h0200, first: 1'b1, hi: 4});
        idx_q.push_back('{idx: 16'h0201, first: 1'b0, hi: 0});
        lat_q.push_back(4);
        lat_q.push_back(4);
        spk_q.push_back(1'b1);
        bus_access(1'b1, 2'd0, 32'h3, 32'd0);
        wait_reqs(2, 50);
        bus_access(1'b1, 2'd0, 32'h6, 32'd0);
        check("abort_req_low", {31'd0, eng_req}, 32'd0);
        bus_access(1'b0, 2'd3, 32'd0, 32'h0001_0000);
        bus_access(1'b1, 2'd1, 32'h0300, 32'd0);
        bus_access(1'b0, 2'd1, 32'd0, 32'h0300);
        lat_q.delete();
        spk_q.delete();

        bus_access(1'b1, 2'd1, 32'h0400, 32'd0);
        bus_access(1'b1, 2'd2, 32'd4, 32'd0);
        idx_q.push_back('{idx: 16'h0400, first: 1'b1, hi: 0});
        lat_q.push_back(4);
        bus_access(1'b1, 2'd0, 32'h3, 32'd0);
        wait_reqs(1, 20);
        @(negedge clk);
        #2;
        check("req_before_reset", {31'd0, eng_req}, 32'd1);
        rstn = 1'b0;
        #1;
        check("reset_req_drop", {31'd0, eng_req}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        idx_q.delete();
        lat_q.delete();
        spk_q.delete();
        bus_access(1'b0, 2'd3, 32'd0, 32'd0);
        bus_access(1'b0, 2'd1, 32'd0, 32'd0);
        bus_access(1'b0, 2'd2, 32'd0, 32'd0);
        bus_access(1'b0, 2'd0, 32'd0, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("idx_q_drained", 32'(idx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cfs_neuron_scheduler.md
CFS_NEURON_SCHEDULER -- requirements
Module: cfs_neuron_scheduler

Interface
REQ-001 SHALL have parameter IDX_W, default 16, width of neuron index, BASE and COUNT fields.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles one engine request may stay unacknowledged.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports bus_re_i / bus_we_i  input  1 each  CPU read/write strobe, one-cycle pulse.
REQ-006 SHALL have port bus_addr_i  input  2  word offset: 0 CTRL, 1 BASE, 2 COUNT, 3 STATUS.
REQ-007 SHALL have port bus_wdata_i  input  32  write data.
REQ-008 SHALL have port bus_rdata_o  output  32  read data, valid only with bus_ack_o, else 0.
REQ-009 SHALL have port bus_ack_o  output  1  access acknowledge.
REQ-010 SHALL have port eng_req_o  output  1  neuron-update request to LIF engine.
REQ-011 SHALL have port eng_idx_o  output  IDX_W  neuron index for current request.
REQ-012 SHALL have ports eng_ack_i / eng_spike_i  input  1 each  engine completion; spike result sampled with ack.
REQ-013 SHALL have port irq_o  output  1  completion interrupt, level.

Function
REQ-014 SHALL assert bus_ack_o exactly one cycle after any bus_re_i or bus_we_i, for every address.
REQ-015 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (r/w), bit2 ABORT (write-1 pulse, reads 0).
REQ-016 BASE and COUNT SHALL be r/w in bits IDX_W-1:0, upper bits read 0; writes while BUSY ignored.
REQ-017 STATUS read-only except W1C: bit0 BUSY, bit1 DONE (sticky, W1C), bit2 TIMEOUT (sticky, W1C), bits 31:16 SPIKES.
REQ-018 FSM states: IDLE, ISSUE, GAP, FINISH.
REQ-019 IDLE: START with COUNT!=0 -> ISSUE, k=0, SPIKES=0, DONE/TIMEOUT cleared; START with COUNT==0 -> FINISH, zero engine requests.
REQ-020 ISSUE: eng_req_o=1, eng_idx_o=BASE+k modulo 2^IDX_W; both held stable until eng_ack_i.
REQ-021 On eng_ack_i in ISSUE: SPIKES += eng_spike_i, saturating at 0xFFFF; if k==COUNT-1 -> FINISH, else k++ -> GAP.
REQ-022 GAP: eng_req_o=0 for exactly one cycle, then ISSUE; eng_ack_i ignored outside ISSUE.
REQ-023 Wait counter SHALL reset on entry to ISSUE; reaching TIMEOUT_CYCLES without ack -> set TIMEOUT, -> FINISH.
REQ-024 FINISH: one cycle, sets DONE, -> IDLE.
REQ-025 BUSY=1 in ISSUE, GAP, FINISH; START while BUSY ignored.
REQ-026 ABORT while BUSY -> IDLE next cycle, eng_req_o low, DONE not set, SPIKES retained; ABORT in IDLE no effect.
REQ-027 Same-cycle DONE set and DONE W1C: set wins; same for TIMEOUT.
REQ-028 Same-cycle START and ABORT in IDLE: ABORT wins, no run starts.
REQ-029 irq_o = IRQ_EN AND DONE, registered-free combinational of flags.
REQ-030 eng_idx_o SHALL be 0 whenever eng_req_o is 0.

Reset
REQ-031 On rstn_i low, asynchronously: state IDLE, all registers and counters 0, bus_ack_o=0, bus_rdata_o=0, eng_req_o=0, eng_idx_o=0, irq_o=0.
REQ-032 Reset mid-run SHALL drop eng_req_o immediately; no run resumes after release.
REQ-033 First access accepted on first rising edge with rstn_i high.

Verification
REQ-034 BASE=0x0010, COUNT=3, engine acks after 2 cycles, spikes 1,0,1 -> idx 0x10,0x11,0x12 with 1-cycle gaps, SPIKES=2, DONE=1.
REQ-035 BASE=0xFFFE, COUNT=4 -> idx 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-036 COUNT=0, START, IRQ_EN=1 -> no eng_req_o, DONE=1 two cycles after write, irq_o=1; W1C STATUS bit1 -> irq_o=0.
REQ-037 TIMEOUT_CYCLES=8, engine never acks -> TIMEOUT=1, DONE=1 after 8 cycles in ISSUE, eng_req_o low.
REQ-038 ABORT during 2nd of 5 requests -> eng_req_o low next cycle, BUSY=0, DONE=0; BASE write then accepted.
REQ-039 rstn_i low mid-run while eng_req_o=1 -> eng_req_o=0 same cycle, STATUS reads 0 after release.
